// File: rtl/mem_sys_pkg.sv
// Shared types, latency bounds and address-geometry helpers for mem_sys.
package mem_sys_pkg;

    // Which request port a response belongs to.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Legal range of the response latency parameter.
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    // Number of byte lanes in a data word.
    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Number of low address bits that select a byte within a word.
    function automatic int unsigned offset_bits(input int unsigned data_w);
        return (data_w <= 8) ? 0 : $clog2(data_w / 8);
    endfunction

    // Number of address bits that select a word (DEPTH is a power of 2, at least 2).
    function automatic int unsigned index_bits(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_sys_if.sv
// Bundle of the instruction-fetch and data request/response signals of mem_sys.
// The master side issues requests; the slave side is the memory.
interface mem_sys_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    import mem_sys_pkg::*;

    logic                            i_req_valid;
    logic                            i_req_ready;
    logic [ADDR_W-1:0]               i_addr;
    logic                            i_rsp_valid;
    logic [DATA_W-1:0]               i_rsp_data;

    logic                            d_req_valid;
    logic                            d_req_ready;
    logic                            d_we;
    logic [byte_lanes(DATA_W)-1:0]   d_be;
    logic [ADDR_W-1:0]               d_addr;
    logic [DATA_W-1:0]               d_wdata;
    logic                            d_rsp_valid;
    logic [DATA_W-1:0]               d_rsp_data;

    modport master (
        output i_req_valid, i_addr,
        output d_req_valid, d_we, d_be, d_addr, d_wdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data
    );

    modport slave (
        input  i_req_valid, i_addr,
        input  d_req_valid, d_we, d_be, d_addr, d_wdata,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data
    );

endinterface

// File: rtl/mem_sys_pipe.sv
// LATENCY-stage response delay line: carries (valid, port, data) from the
// access cycle to the response cycle. Idle stages hold zero data.
module mem_sys_pipe
    import mem_sys_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  port_e             in_port,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output port_e             out_port,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q, valid_d;
    port_e              port_q [LATENCY];
    port_e              port_d [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];

    // Stage 0 captures the new access; every later stage takes its predecessor.
    always_comb begin
        valid_d[0] = in_valid;
        port_d[0]  = in_port;
        data_d[0]  = in_valid ? in_data : '0;
        for (int s = 1; s < LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            port_d[s]  = port_q[s-1];
            data_d[s]  = data_q[s-1];
        end
    end

    // Delay registers; reset drops every response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                port_q[s] <= PORT_I;
                data_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            port_q  <= port_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_port  = port_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_sys.sv
// Single-port word memory shared by an instruction-fetch port and a data
// port. Round-robin arbitration picks at most one access per cycle; every
// accepted request gets exactly one response LATENCY cycles later.
module mem_sys
    import mem_sys_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rsp_valid,
    output logic [DATA_W-1:0]   i_rsp_data,

    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data
);

    localparam int LANES = int'(byte_lanes(DATA_W));
    localparam int OFF_W = int'(offset_bits(DATA_W));
    localparam int IDX_W = int'(index_bits(DEPTH));

    // prio_d_q = 1 means the data port wins the next contended cycle.
    logic              prio_d_q, prio_d_d;
    logic              i_fire, d_fire;

    logic [IDX_W-1:0]  idx;
    logic              wr_en;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_valid;
    port_e             acc_port;
    logic [DATA_W-1:0] acc_data;

    logic              rsp_valid;
    port_e             rsp_port;
    logic [DATA_W-1:0] rsp_data;

    // Only the word-index bits of each address select storage; the rest wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr, d_addr};

    // Arbitration: each ready depends only on the other port's valid and the priority bit.
    // NOTE: every signal written in an always_comb gets a value on every path, defaults first, so no latch is inferred.
    always_comb begin
        i_req_ready = !(d_req_valid && prio_d_q);
        d_req_ready = !(i_req_valid && !prio_d_q);
        i_fire      = i_req_valid && i_req_ready;
        d_fire      = d_req_valid && d_req_ready;
        prio_d_d    = prio_d_q;
        if (i_req_valid && d_req_valid) begin
            prio_d_d = !prio_d_q;
        end
    end

    // Access: pick the granted port's word, merge write bytes, capture read data.
    always_comb begin
        idx      = d_fire ? d_addr[OFF_W +: IDX_W] : i_addr[OFF_W +: IDX_W];
        wr_en    = d_fire && d_we;
        wr_word  = mem_q[idx];
        for (int b = 0; b < LANES; b++) begin
            if (d_be[b]) begin
                wr_word[b*8 +: 8] = d_wdata[b*8 +: 8];
            end
        end
        acc_valid = i_fire || d_fire;
        acc_port  = d_fire ? PORT_D : PORT_I;
        acc_data  = wr_en ? '0 : mem_q[idx];
    end

    // Priority register, data-first out of reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_d_q <= 1'b1;
        end else begin
            prio_d_q <= prio_d_d;
        end
    end

    // Storage write port; a write with no byte enables rewrites the old word unchanged.
    // NOTE: the array deliberately has no reset branch: contents survive rst_n, and an unreset array can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end

    mem_sys_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc_valid),
        .in_port   (acc_port),
        .in_data   (acc_data),
        .out_valid (rsp_valid),
        .out_port  (rsp_port),
        .out_data  (rsp_data)
    );

    // Steer the delayed response to its port; data is zero whenever valid is low.
    always_comb begin
        i_rsp_valid = rsp_valid && (rsp_port == PORT_I);
        d_rsp_valid = rsp_valid && (rsp_port == PORT_D);
        i_rsp_data  = i_rsp_valid ? rsp_data : '0;
        d_rsp_data  = d_rsp_valid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_mem_sys.sv
// Bench for mem_sys: four instances (LATENCY 1..4) share one stimulus stream.
// Directed vector table, hand-written arbitration/reset sequences, random
// traffic, and a per-cycle reference model checking every instance.
module tb_mem_sys;
    import mem_sys_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam int NVEC  = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        iv, dv, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;

    // Outputs collected per latency
    logic [4:1]  o_ir, o_dr, o_irv, o_drv;
    logic [31:0] o_ird [1:4];
    logic [31:0] o_drd [1:4];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 1; g <= 4; g++) begin : g_lat
        mem_sys_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

        assign bus.i_req_valid = iv;
        assign bus.i_addr      = ia;
        assign bus.d_req_valid = dv;
        assign bus.d_we        = dwe;
        assign bus.d_be        = dbe;
        assign bus.d_addr      = da;
        assign bus.d_wdata     = dwd;

        mem_sys #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .DEPTH   (DEPTH),
            .LATENCY (g)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_req_valid (bus.i_req_valid),
            .i_req_ready (bus.i_req_ready),
            .i_addr      (bus.i_addr),
            .i_rsp_valid (bus.i_rsp_valid),
            .i_rsp_data  (bus.i_rsp_data),
            .d_req_valid (bus.d_req_valid),
            .d_req_ready (bus.d_req_ready),
            .d_we        (bus.d_we),
            .d_be        (bus.d_be),
            .d_addr      (bus.d_addr),
            .d_wdata     (bus.d_wdata),
            .d_rsp_valid (bus.d_rsp_valid),
            .d_rsp_data  (bus.d_rsp_data)
        );

        assign o_ir[g]  = bus.i_req_ready;
        assign o_dr[g]  = bus.d_req_ready;
        assign o_irv[g] = bus.i_rsp_valid;
        assign o_drv[g] = bus.d_rsp_valid;
        assign o_ird[g] = bus.i_rsp_data;
        assign o_drd[g] = bus.d_rsp_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic        m_prio = 1'b1;
    logic        m_v   [1:4][1:4];
    logic        m_isd [1:4][1:4];
    logic [31:0] m_dat [1:4][1:4];

    // One model step per cycle, called at the falling edge.
    task automatic sb_step();
        logic        gi, gd, wr, ev_i, ev_d;
        logic [7:0]  w;
        logic [31:0] rd;
        if (!rst_n) begin
            for (int l = 1; l <= 4; l++) begin
                check($sformatf("rst_L%0d_i_rsp_valid", l), 32'(o_irv[l]), 32'd0);
                check($sformatf("rst_L%0d_d_rsp_valid", l), 32'(o_drv[l]), 32'd0);
                check($sformatf("rst_L%0d_i_rsp_data", l), o_ird[l], 32'd0);
                check($sformatf("rst_L%0d_d_rsp_data", l), o_drd[l], 32'd0);
                for (int s = 1; s <= 4; s++) m_v[l][s] = 1'b0;
            end
            m_prio = 1'b1;
        end else begin
            for (int l = 1; l <= 4; l++) begin
                ev_i = m_v[l][1] && !m_isd[l][1];
                ev_d = m_v[l][1] && m_isd[l][1];
                check($sformatf("sb_L%0d_i_rsp_valid", l), 32'(o_irv[l]), 32'(ev_i));
                check($sformatf("sb_L%0d_i_rsp_data", l), o_ird[l], ev_i ? m_dat[l][1] : 32'd0);
                check($sformatf("sb_L%0d_d_rsp_valid", l), 32'(o_drv[l]), 32'(ev_d));
                check($sformatf("sb_L%0d_d_rsp_data", l), o_drd[l], ev_d ? m_dat[l][1] : 32'd0);
                check($sformatf("sb_L%0d_i_ready", l), 32'(o_ir[l]), 32'(!(dv && m_prio)));
                check($sformatf("sb_L%0d_d_ready", l), 32'(o_dr[l]), 32'(!(iv && !m_prio)));
            end
            gi = iv && (!dv || !m_prio);
            gd = dv && (!iv || m_prio);
            w  = gd ? da[9:2] : ia[9:2];
            wr = gd && dwe;
            rd = wr ? 32'd0 : m_mem[w];
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (dbe[b]) m_mem[w][b*8 +: 8] = dwd[b*8 +: 8];
                end
            end
            if (iv && dv) m_prio = !m_prio;
            for (int l = 1; l <= 4; l++) begin
                for (int s = 1; s < l; s++) begin
                    m_v[l][s]   = m_v[l][s+1];
                    m_isd[l][s] = m_isd[l][s+1];
                    m_dat[l][s] = m_dat[l][s+1];
                end
                m_v[l][l]   = gi || gd;
                m_isd[l][l] = gd;
                m_dat[l][l] = rd;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        sb_step();
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv = 1'b0; dv = 1'b0; dwe = 1'b0; dbe = 4'h0;
        ia = 32'h0; da = 32'h0; dwd = 32'h0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst_n = 1'b0;
        repeat (n) begin
            sample();
            drive();
        end
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        repeat (n) begin
            sample();
            drive();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_ir;
        logic        e_dr;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs [NVEC];

    // Expected response fields describe the LATENCY=1 instance in the same cycle.
    task automatic load_vectors();
        //           iv    ia      dv    we    be    da      wdata         ir    dr    irv   ird           drv   drd
        vecs[0]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h10,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'h2, 32'h10,  32'h0000AA00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h10,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'hF, 32'h400, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'hDEADAAEF, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h3,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 4'h0, 32'h000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h403, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[11] = '{1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h12345678};
        vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADAAEF, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    endtask

    initial begin
        int  di, ii, rd_d, rd_i, cnt;
        logic exp_d;

        idle_inputs();
        for (int w = 0; w < DEPTH; w++) m_mem[w] = 32'h0;
        do_reset(2);

        // Give every word a known value through the data port.
        for (int w = 0; w < DEPTH; w++) begin
            dv  = 1'b1; dwe = 1'b1; dbe = 4'hF;
            da  = 32'(w) << 2;
            dwd = 32'hA500_0000 | 32'(w);
            sample();
            drive();
        end
        idle_cycles(5);

        // Contents survive a reset; the table starts from data-first priority.
        do_reset(2);
        load_vectors();
        for (int n = 0; n < NVEC; n++) begin
            iv = vecs[n].iv;  ia = vecs[n].ia;
            dv = vecs[n].dv;  dwe = vecs[n].dwe; dbe = vecs[n].dbe;
            da = vecs[n].da;  dwd = vecs[n].dwd;
            sample();
            check($sformatf("vec%0d_i_ready", n), 32'(o_ir[1]), 32'(vecs[n].e_ir));
            check($sformatf("vec%0d_d_ready", n), 32'(o_dr[1]), 32'(vecs[n].e_dr));
            check($sformatf("vec%0d_i_rsp_valid", n), 32'(o_irv[1]), 32'(vecs[n].e_irv));
            check($sformatf("vec%0d_i_rsp_data", n), o_ird[1], vecs[n].e_ird);
            check($sformatf("vec%0d_d_rsp_valid", n), 32'(o_drv[1]), 32'(vecs[n].e_drv));
            check($sformatf("vec%0d_d_rsp_data", n), o_drd[1], vecs[n].e_drd);
            drive();
        end
        idle_cycles(5);

        // Both ports valid for 8 cycles from reset: grants D,I,D,I..., one response per cycle.
        do_reset(1);
        di = 0; ii = 0; rd_d = 0; rd_i = 0;
        for (int k = 0; k <= 8; k++) begin
            iv  = (k < 8); dv = (k < 8); dwe = 1'b0; dbe = 4'h0;
            ia  = 32'h40 + 32'(4 * ii);
            da  = 32'h20 + 32'(4 * di);
            sample();
            if (k < 8) begin
                check($sformatf("rr%0d_d_grant", k), 32'(o_dr[1]), 32'(k % 2 == 0));
                check($sformatf("rr%0d_i_grant", k), 32'(o_ir[1]), 32'(k % 2 == 1));
            end
            if (k > 0) begin
                exp_d = ((k - 1) % 2 == 0);
                check($sformatf("rr%0d_d_rsp_valid", k), 32'(o_drv[1]), 32'(exp_d));
                check($sformatf("rr%0d_i_rsp_valid", k), 32'(o_irv[1]), 32'(!exp_d));
                if (exp_d) begin
                    check($sformatf("rr%0d_d_rsp_data", k), o_drd[1], 32'hA500_0008 + 32'(rd_d));
                    rd_d++;
                end else begin
                    check($sformatf("rr%0d_i_rsp_data", k), o_ird[1], 32'hA500_0010 + 32'(rd_i));
                    rd_i++;
                end
            end
            if (k < 8) begin
                if (k % 2 == 0) di++;
                else            ii++;
            end
            drive();
        end
        idle_cycles(4);

        // One contended cycle hands priority to the fetch port before the reset test.
        iv = 1'b1; ia = 32'h40; dv = 1'b1; dwe = 1'b0; da = 32'h20;
        sample();
        drive();
        idle_inputs();

        // Three back-to-back fetches, then reset one cycle after the last handshake.
        for (int k = 0; k < 3; k++) begin
            iv = 1'b1; ia = 32'h40 + 32'(4 * k);
            sample();
            check($sformatf("l3_fetch%0d_ready", k), 32'(o_ir[3]), 32'd1);
            drive();
        end
        idle_inputs();
        rst_n = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (o_irv[3]) cnt++;
            drive();
            rst_n = 1'b1;
        end
        check("l3_rsp_after_reset", 32'(cnt), 32'd0);

        // Priority is data-first again.
        iv = 1'b1; ia = 32'h44; dv = 1'b1; dwe = 1'b0; da = 32'h24;
        sample();
        check("l3_prio_i_ready", 32'(o_ir[3]), 32'd0);
        check("l3_prio_d_ready", 32'(o_dr[3]), 32'd1);
        drive();
        idle_cycles(5);

        // Random traffic across all latencies, with one reset in the middle.
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset(2);
            iv  = 1'($urandom_range(0, 1));
            ia  = $urandom;
            dv  = 1'($urandom_range(0, 1));
            dwe = 1'($urandom_range(0, 1));
            dbe = 4'($urandom_range(0, 15));
            da  = $urandom;
            dwd = $urandom;
            sample();
            drive();
        end
        idle_cycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
